// File: rtl/demux_rr_n.sv
// demux_rr_n: 1:NUM_LANES word demultiplexer for the phy_rx datapath, clk_2f domain.
// Steers each valid input word to one lane, either round-robin or by an explicit
// lane id. Outputs are registered; unselected lanes hold their last data word.
// In round-robin mode, a run of GAP_RESYNC idle cycles sends the pointer back to lane 0.
// Optional macro DEMUX_PARITY_EN adds a per-lane parity output, registered with the data.
//
// state  | meaning
// IDLE   | no round-robin traffic since reset/resync; sel_cur is 0
// ACTIVE | round-robin traffic seen; idle cycles are counted toward resync
module demux_rr_n #(
    parameter int DATA_W     = 8,
    parameter int NUM_LANES  = 4,
    parameter int GAP_RESYNC = 2,
    localparam int SEL_W     = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
    input  logic                        clk_2f,
    input  logic                        reset_L,
    input  logic [DATA_W-1:0]           data_unstripped,
    input  logic                        valid_unstripped,
    input  logic                        mode_dir,
    input  logic [SEL_W-1:0]            lane_id,
    output logic [NUM_LANES*DATA_W-1:0] data_demux,
    output logic [NUM_LANES-1:0]        valid_demux,
    output logic [SEL_W-1:0]            sel_cur,
    output logic                        frame_done,
    output logic                        err_drop
`ifdef DEMUX_PARITY_EN
    ,output logic [NUM_LANES-1:0]       parity_demux
`endif
);

    localparam int GAP_W = (GAP_RESYNC > 0) ? $clog2(GAP_RESYNC + 1) : 1;
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_LANES - 1);
    // Compared against the count before increment, so the threshold is hit on this cycle.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_RESYNC > 0) ? GAP_RESYNC - 1 : 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             lane_ok;
    logic             wr_en;
    logic [SEL_W-1:0] wr_lane;

    // Pick the target lane for this cycle and decide whether a write happens.
    always_comb begin
        lane_ok = (int'(lane_id) < NUM_LANES);
        wr_en   = 1'b0;
        wr_lane = sel_cur;
        if (valid_unstripped) begin
            if (mode_dir) begin
                wr_lane = lane_id;
                wr_en   = lane_ok;
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    // Lane registers, round-robin pointer, gap-resync FSM and status pulses.
    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            data_demux   <= '0;
            valid_demux  <= '0;
            sel_cur      <= '0;
            frame_done   <= 1'b0;
            err_drop     <= 1'b0;
            gap_cnt      <= '0;
            state        <= IDLE;
`ifdef DEMUX_PARITY_EN
            parity_demux <= '0;
`endif
        end else begin
            valid_demux <= '0;
            frame_done  <= 1'b0;
            err_drop    <= 1'b0;

            for (int k = 0; k < NUM_LANES; k++) begin
                if (wr_en && (int'(wr_lane) == k)) begin
                    data_demux[k*DATA_W +: DATA_W] <= data_unstripped;
                    valid_demux[k]                 <= 1'b1;
`ifdef DEMUX_PARITY_EN
                    parity_demux[k]                <= ^data_unstripped;
`endif
                end
            end

            if (mode_dir) begin
                // Directed cycles leave the pointer and the gap counter untouched.
                if (valid_unstripped && !lane_ok) begin
                    err_drop <= 1'b1;
                end
            end else if (valid_unstripped) begin
                frame_done <= (sel_cur == LAST_LANE);
                sel_cur    <= (sel_cur == LAST_LANE) ? '0 : sel_cur + 1'b1;
                gap_cnt    <= '0;
                state      <= ACTIVE;
            end else if ((state == ACTIVE) && (GAP_RESYNC != 0)) begin
                if (gap_cnt >= GAP_LAST) begin
                    sel_cur <= '0;
                    gap_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_n.sv
// Scoreboard bench for demux_rr_n: a 4-lane and a 3-lane instance share one stimulus
// stream. A lane-array reference model predicts each cycle's outputs into per-instance
// queues. A monitor pops those queues one cycle later and compares them with the DUTs.
module tb_demux_rr_n;

    logic       clk_2f = 1'b0;
    logic       reset_L;
    logic [7:0] data_unstripped;
    logic       valid_unstripped;
    logic       mode_dir;
    logic [1:0] lane_id;

    logic [31:0] data_demux4;
    logic [3:0]  valid_demux4;
    logic [1:0]  sel_cur4;
    logic        frame_done4, err_drop4;
    logic [23:0] data_demux3;
    logic [2:0]  valid_demux3;
    logic [1:0]  sel_cur3;
    logic        frame_done3, err_drop3;
`ifdef DEMUX_PARITY_EN
    logic [3:0]  parity_demux4;
    logic [2:0]  parity_demux3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_2f = ~clk_2f;

    demux_rr_n #(.DATA_W(8), .NUM_LANES(4), .GAP_RESYNC(2)) u_dut4 (
        .clk_2f(clk_2f), .reset_L(reset_L), .data_unstripped(data_unstripped),
        .valid_unstripped(valid_unstripped), .mode_dir(mode_dir), .lane_id(lane_id),
        .data_demux(data_demux4), .valid_demux(valid_demux4), .sel_cur(sel_cur4),
        .frame_done(frame_done4), .err_drop(err_drop4)
`ifdef DEMUX_PARITY_EN
        , .parity_demux(parity_demux4)
`endif
    );

    demux_rr_n #(.DATA_W(8), .NUM_LANES(3), .GAP_RESYNC(2)) u_dut3 (
        .clk_2f(clk_2f), .reset_L(reset_L), .data_unstripped(data_unstripped),
        .valid_unstripped(valid_unstripped), .mode_dir(mode_dir), .lane_id(lane_id),
        .data_demux(data_demux3), .valid_demux(valid_demux3), .sel_cur(sel_cur3),
        .frame_done(frame_done3), .err_drop(err_drop3)
`ifdef DEMUX_PARITY_EN
        , .parity_demux(parity_demux3)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  valid;
        logic [1:0]  sel;
        logic        fd;
        logic        err;
        logic [3:0]  par;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    // Reference state: lane contents, pointer, and a count of consecutive idle round-robin cycles.
    logic [7:0] m_lane [2][4];
    int         m_ptr  [2];
    int         m_idle [2];
    localparam int GAP = 2;

    function automatic exp_t model_step(int idx, int n, logic rst_n, logic v, logic md,
                                        logic [7:0] d, logic [1:0] id);
        exp_t e;
        e.valid = '0;
        e.fd    = 1'b0;
        e.err   = 1'b0;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_lane[idx][k] = 8'h00;
            m_ptr[idx]  = 0;
            m_idle[idx] = 0;
        end else if (!md) begin
            if (v) begin
                m_lane[idx][m_ptr[idx]] = d;
                e.valid[m_ptr[idx]]     = 1'b1;
                e.fd                    = (m_ptr[idx] == n - 1);
                m_ptr[idx]              = (m_ptr[idx] + 1) % n;
                m_idle[idx]             = 0;
            end else begin
                m_idle[idx]++;
                if (m_idle[idx] >= GAP) begin
                    m_ptr[idx]  = 0;
                    m_idle[idx] = 0;
                end
            end
        end else if (v) begin
            if (int'(id) < n) begin
                m_lane[idx][id] = d;
                e.valid[id]     = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end
        e.data = '0;
        e.par  = '0;
        for (int k = 0; k < n; k++) begin
            e.data[k*8 +: 8] = m_lane[idx][k];
            e.par[k]         = ^m_lane[idx][k];
        end
        e.sel = 2'(m_ptr[idx]);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(logic rst_n, logic v, logic md, logic [7:0] d, logic [1:0] id);
        @(negedge clk_2f);
        reset_L          = rst_n;
        valid_unstripped = v;
        mode_dir         = md;
        data_unstripped  = d;
        lane_id          = id;
        q4.push_back(model_step(0, 4, rst_n, v, md, d, id));
        q3.push_back(model_step(1, 3, rst_n, v, md, d, id));
    endtask

    // Monitor: after every clock edge, pop each instance's pending expectation and compare.
    always begin
        exp_t e;
        @(posedge clk_2f);
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("n4_data",  data_demux4,          e.data);
            chk("n4_valid", {28'd0, valid_demux4}, {28'd0, e.valid});
            chk("n4_sel",   {30'd0, sel_cur4},    {30'd0, e.sel});
            chk("n4_frame", {31'd0, frame_done4}, {31'd0, e.fd});
            chk("n4_err",   {31'd0, err_drop4},   {31'd0, e.err});
`ifdef DEMUX_PARITY_EN
            chk("n4_par",   {28'd0, parity_demux4}, {28'd0, e.par});
`endif
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("n3_data",  {8'd0, data_demux3},  e.data);
            chk("n3_valid", {29'd0, valid_demux3}, {28'd0, e.valid});
            chk("n3_sel",   {30'd0, sel_cur3},    {30'd0, e.sel});
            chk("n3_frame", {31'd0, frame_done3}, {31'd0, e.fd});
            chk("n3_err",   {31'd0, err_drop3},   {31'd0, e.err});
`ifdef DEMUX_PARITY_EN
            chk("n3_par",   {29'd0, parity_demux3}, {28'd0, e.par});
`endif
        end
    end

    initial begin
        reset_L          = 1'b0;
        valid_unstripped = 1'b0;
        mode_dir         = 1'b0;
        data_unstripped  = 8'h00;
        lane_id          = 2'd0;

        drive(0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 0);

        // Eight back-to-back round-robin words.
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 8'h10 + 8'(i), 0);

        // Two words, a two-cycle gap, then a word that must land on lane 0.
        drive(1, 1, 0, 8'hA0, 0);
        drive(1, 1, 0, 8'hA1, 0);
        drive(1, 0, 0, 8'hEE, 0);
        drive(1, 0, 0, 8'hEE, 0);
        drive(1, 1, 0, 8'hA2, 0);

        // Directed to lane 2, then lane 3 (legal on 4 lanes, dropped on 3).
        drive(1, 1, 1, 8'h5C, 2);
        drive(1, 1, 1, 8'h99, 3);
        drive(1, 0, 1, 8'h00, 0);

        // Hold: write lane 1 then idle for five cycles.
        drive(0, 0, 0, 8'h00, 0);
        drive(1, 1, 0, 8'h32, 0);
        drive(1, 1, 0, 8'h33, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'hFF, 0);

        // Reset mid-stream, then the next word goes to lane 0.
        drive(1, 1, 0, 8'h41, 0);
        drive(1, 1, 0, 8'h42, 0);
        drive(0, 1, 0, 8'h43, 0);
        drive(1, 1, 0, 8'h77, 0);

        // Seven words for the 3-lane wrap; 0x07 ends up on lane 0.
        drive(0, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 7; i++) drive(1, 1, 0, 8'(i), 0);

        // Randomized traffic: mixed modes, gaps, lane ids and occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 60) != 0, ($urandom % 4) < 2, ($urandom % 4) == 0,
                  8'($urandom), 2'($urandom % 4));
        end
        drive(1, 0, 0, 8'h00, 0);

        for (int i = 0; i < 10 && (q4.size() > 0 || q3.size() > 0); i++) @(posedge clk_2f);
        #2;
        total++;
        if (q4.size() > 0 || q3.size() > 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q4.size() + q3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
